mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- M-stage initiator for the data memory port: turns pipeline load/store requests into word-aligned memory transactions with byte enables, lane-replicated write data and a req/ack handshake.
- Returns sign/zero-extended load data to the pipeline.
- Stalls the pipeline while a transaction is outstanding.
- Flags misaligned or illegal accesses and memory timeouts.

Parameters:
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (1..65535).
- CNT_W, 16, width of the wait counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  M stage holds a memory op
- req_re  in  1  op is a load
- req_we  in  1  op is a store
- ldst_type  in  3  000 word, 001 byte, 010 byte unsigned, 011 half, 100 half unsigned
- addr  in  32  byte address
- wdata_in  in  32  store data, right-justified
- pc  in  32  PC of the op
- mem_req  out  1  transaction request
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes the current request
- mem_rdata  in  32  raw word, valid with mem_ack
- stall  out  1  hold the pipeline
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  extended load result
- addr_err  out  1  one-cycle pulse: misaligned or illegal request
- bus_err  out  1  one-cycle pulse: timeout
- err_pc  out  32  pc of the faulting op

Behaviour:
- Reset state:
  - State IDLE.
  - All outputs 0.
  - Wait counter 0.
- Reset mid-transaction:
  - Same reset values; the request is dropped.
  - A late mem_ack is ignored.
- Request legality (IDLE only):
  - Illegal if any of: req_re and req_we both set; word access with addr[1:0]!=0; half access with addr[0]!=0; ldst_type >100; store with type 010 or 100.
  - Illegal request: no mem_req. Next cycle addr_err=1 for one cycle and err_pc=pc. stall=0. State stays IDLE.
- Store byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: one-hot 0001 << addr[1:0].
- Store data:
  - byte: {4{wdata_in[7:0]}}.
  - half: {2{wdata_in[15:0]}}.
  - word: as-is.
- Loads: mem_be=1111, mem_wdata=0.
- FSM:
  - IDLE: a legal request registers mem_addr, mem_be, mem_wdata, mem_we, type, addr[1:0] and pc, then goes to BUSY.
  - BUSY: mem_req=1; all mem_* outputs are stable until ack. The counter increments each cycle.
    - On mem_ack: go to DONE. For a load, register ld_data and set ld_valid=1 for one cycle.
    - If the counter reaches TIMEOUT-1 without ack: drop mem_req, pulse bus_err, set err_pc, go to DONE.
  - DONE: one cycle, mem_req=0, then back to IDLE. The incoming request is ignored in DONE; it is the op just completed while the pipeline advances.
- stall:
  - Combinational.
  - =1 when req_valid and legal in IDLE, or state==BUSY.
  - =0 in DONE.
- Latency:
  - An ack in the first BUSY cycle gives ld_valid 2 cycles after the request is presented.
  - Minimum occupancy is 3 cycles per access.
- Load extraction, using the registered addr[1:0]:
  - byte: lane addr[1:0], sign-extended (001) or zero-extended (010).
  - half: lane addr[1], sign-extended (011) or zero-extended (100).
  - word: raw.
- Simultaneous events:
  - mem_ack on the same cycle as the timeout: ack wins, no bus_err.
  - mem_ack while not BUSY: ignored.

Decomposition:
- Package mem_pkg holds:
  - LdStType codes: LS_W, LS_B, LS_BU, LS_H, LS_HU.
  - FSM state encodings: IDLE, BUSY, DONE.
- Sub-module load_ext: combinational lane select and extend, with inputs raw word, type and lsb.

Test Plan:
- Load word, ack in first BUSY cycle:
  - Stimulus: addr 0x0000_0010 word load, mem_rdata 0x8765_4321.
  - Response: mem_be=1111, mem_addr=0x10, ld_data=0x8765_4321; stall high 2 cycles, ld_valid 1 pulse.
- Byte loads:
  - Stimulus: mem_rdata 0x80FF_7F01, addr[1:0]=01; then addr[1:0]=11.
  - Response for 01: type 001 gives 0x0000_007F, type 010 gives 0x0000_007F.
  - Response for 11: type 001 gives 0xFFFF_FF80, type 010 gives 0x0000_0080.
- Stores:
  - sh, addr 0x22, wdata_in 0x1234_ABCD → mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x20.
  - sb, addr 0x23 → mem_be=1000.
- Misaligned load word:
  - Stimulus: addr 0x0000_0006, pc 0x3004.
  - Response: mem_req stays 0; next cycle addr_err pulse, err_pc=0x3004; stall 0.
- Timeout:
  - Stimulus: TIMEOUT=4, mem_ack held low.
  - Response: mem_req high 4 cycles then drops; bus_err pulse; back to IDLE after DONE. An ack arriving on the timeout cycle instead produces ld_valid and no bus_err.
- Reset mid-BUSY:
  - Stimulus: reset in the 2nd wait cycle, then mem_ack the next cycle.
  - Response: all outputs 0, no ld_valid, state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: load/store type codes,
// FSM states and the store byte-enable helper.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [2:0] {
    LS_W  = 3'b000,
    LS_B  = 3'b001,
    LS_BU = 3'b010,
    LS_H  = 3'b011,
    LS_HU = 3'b100
  } ldst_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Byte enables of a store, from access size and the low address bits.
  function automatic logic [BE_W-1:0] store_be(input logic [2:0] t, input logic [1:0] lsb);
    logic [BE_W-1:0] be;
    be = 4'b1111;
    case (t)
      LS_B:    be = 4'b0001 << lsb;
      LS_H:    be = lsb[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Lane select and sign/zero extension of a raw memory word for loads.
module load_ext
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      type_i,
  input  logic [1:0]      lsb_i,
  output logic [XLEN-1:0] data_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c   = raw_i[7:0];
    half_c   = lsb_i[1] ? raw_i[31:16] : raw_i[15:0];
    data_c_o = raw_i;
    case (lsb_i)
      2'b00:   byte_c = raw_i[7:0];
      2'b01:   byte_c = raw_i[15:8];
      2'b10:   byte_c = raw_i[23:16];
      default: byte_c = raw_i[31:24];
    endcase
    case (ldst_e'(type_i))
      LS_B:    data_c_o = {{24{byte_c[7]}}, byte_c};
      LS_BU:   data_c_o = {24'h0, byte_c};
      LS_H:    data_c_o = {{16{half_c[15]}}, half_c};
      LS_HU:   data_c_o = {16'h0, half_c};
      default: data_c_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory initiator: legality check, byte enables and lane
// replication, req/ack handshake with timeout, and load-data extension.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_re,
  input  logic            req_we,
  input  logic [2:0]      ldst_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata_in,
  input  logic [XLEN-1:0] pc,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic            ld_valid,
  output logic [XLEN-1:0] ld_data,
  output logic            addr_err,
  output logic            bus_err,
  output logic [XLEN-1:0] err_pc
);

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            mem_req_q, mem_we_q, ld_valid_q, addr_err_q, bus_err_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, ld_data_q, err_pc_q, pc_q;
  logic [BE_W-1:0] mem_be_q;
  logic [2:0]      type_q;
  logic [1:0]      lsb_q;

  logic            is_word_c, is_half_c, is_byte_c, is_op_c, illegal_c;
  logic            go_c, bad_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, ext_c;

  // Request decode: legality, store lanes and data replication.
  always_comb begin
    is_word_c = (ldst_type == LS_W);
    is_half_c = (ldst_type == LS_H) || (ldst_type == LS_HU);
    is_byte_c = (ldst_type == LS_B) || (ldst_type == LS_BU);
    is_op_c   = req_re | req_we;
    illegal_c = (req_re & req_we)
              | (is_word_c & (addr[1:0] != 2'b00))
              | (is_half_c & addr[0])
              | (ldst_type > 3'b100)
              | (req_we & ((ldst_type == LS_BU) || (ldst_type == LS_HU)));
    go_c      = (state_q == IDLE) & req_valid & is_op_c & ~illegal_c;
    bad_c     = (state_q == IDLE) & req_valid & is_op_c & illegal_c;
    be_c      = 4'b1111;
    wdata_c   = '0;
    if (req_we) begin
      be_c = store_be(ldst_type, addr[1:0]);
      if (is_byte_c)      wdata_c = {4{wdata_in[7:0]}};
      else if (is_half_c) wdata_c = {2{wdata_in[15:0]}};
      else                wdata_c = wdata_in;
    end
  end

  load_ext u_load_ext (
    .raw_i    (mem_rdata),
    .type_i   (type_q),
    .lsb_i    (lsb_q),
    .data_c_o (ext_c)
  );

  // Transaction FSM; all outputs except stall are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      err_pc_q    <= '0;
      pc_q        <= '0;
      type_q      <= '0;
      lsb_q       <= '0;
    end else begin
      ld_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_c) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_be_q    <= be_c;
            mem_wdata_q <= wdata_c;
            type_q      <= ldst_type;
            lsb_q       <= addr[1:0];
            pc_q        <= pc;
          end else if (bad_c) begin
            addr_err_q <= 1'b1;
            err_pc_q   <= pc;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              ld_valid_q <= 1'b1;
              ld_data_q  <= ext_c;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            err_pc_q  <= pc_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall     = go_c | (state_q == BUSY);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign err_pc    = err_pc_q;

endmodule
